// File: rtl/prefix_add_pipe.sv
// prefix_add_pipe: 3-stage pipelined 16-bit Kogge-Stone adder/subtractor.
// Stage 1 holds (P,G) after prefix levels 1-2, stage 2 holds G after levels
// 3-4, and stage 3 is the registered result. valid/ready handshakes on both
// sides; in_ready is combinational from out_ready through the stage chain.
module prefix_add_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    // Prefix distances of the four Kogge-Stone levels.
    localparam int unsigned D1 = 32'd1;
    localparam int unsigned D2 = 32'd2;
    localparam int unsigned D3 = 32'd4;
    localparam int unsigned D4 = 32'd8;

    typedef struct packed {
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
    } pg_t;

    // One black-cell level at distance d. Bits below d pass through: the
    // shifted-in generate bits are zero and the low mask keeps P unchanged.
    function automatic pg_t black_level(input pg_t x, input int unsigned d);
        pg_t              y;
        logic [WIDTH-1:0] low_mask;
        low_mask = ~({WIDTH{1'b1}} << d);
        y.g      = x.g | (x.p & (x.g << d));
        y.p      = x.p & ((x.p << d) | low_mask);
        return y;
    endfunction

    // ---------------- combinational signals ----------------
    logic [WIDTH-1:0] b_eff_s;
    logic             c0_s;
    logic [WIDTH-1:0] half_s;
    pg_t              pre_s;
    pg_t              lvl2_s;
    pg_t              lvl3_s;
    logic [WIDTH-1:0] lvl4_g_s;
    logic [WIDTH-1:0] sum_s;
    logic             cout_s;
    logic             ovf_s;
    logic             zero_s;
    logic             s1_free_s;
    logic             s2_free_s;
    logic             s3_free_s;

    // ---------------- stage registers ----------------
    logic             s1_v_r;
    pg_t              s1_pg_r;
    logic [WIDTH-1:0] s1_h_r;
    logic             s1_a15_r;
    logic             s1_b15_r;
    logic             s1_c0_r;
    logic [TAG_W-1:0] s1_tag_r;

    logic             s2_v_r;
    logic [WIDTH-1:0] s2_g_r;
    logic [WIDTH-1:0] s2_h_r;
    logic             s2_a15_r;
    logic             s2_b15_r;
    logic             s2_c0_r;
    logic [TAG_W-1:0] s2_tag_r;

    logic             out_valid_r;
    logic [WIDTH-1:0] out_sum_r;
    logic             out_cout_r;
    logic             out_ovf_r;
    logic             out_zero_r;
    logic [TAG_W-1:0] out_tag_r;

    // Stage occupancy chain: a stage can load when empty or when its content moves on.
    always_comb begin
        s3_free_s = ~out_valid_r | out_ready;
        s2_free_s = ~s2_v_r | s3_free_s;
        s1_free_s = ~s1_v_r | s2_free_s;
    end

    assign in_ready = s1_free_s;

    // Pre-processing and prefix levels 1-2; carry-in is folded into bit 0's generate.
    always_comb begin
        b_eff_s    = in_sub ? ~in_b : in_b;
        c0_s       = in_sub ? 1'b1 : in_cin;
        half_s     = in_a ^ b_eff_s;
        pre_s.g    = in_a & b_eff_s;
        pre_s.g[0] = (in_a[0] & b_eff_s[0]) | (half_s[0] & c0_s);
        pre_s.p    = half_s;
        pre_s.p[0] = 1'b0;
        lvl2_s     = black_level(black_level(pre_s, D1), D2);
    end

    // Prefix levels 3-4; the final level only needs G, since P is dead afterwards.
    always_comb begin
        lvl3_s   = black_level(s1_pg_r, D3);
        lvl4_g_s = lvl3_s.g | (lvl3_s.p & (lvl3_s.g << D4));
    end

    // Post-processing: G[i-1] is the carry into bit i, G[15] the carry out.
    always_comb begin
        sum_s[0]         = s2_h_r[0] ^ s2_c0_r;
        sum_s[WIDTH-1:1] = s2_h_r[WIDTH-1:1] ^ s2_g_r[WIDTH-2:0];
        cout_s           = s2_g_r[WIDTH-1];
        ovf_s            = (s2_a15_r == s2_b15_r) & (sum_s[WIDTH-1] != s2_a15_r);
        zero_s           = (sum_s == {WIDTH{1'b0}});
    end

    // Stage 1 register: accepts a new operation whenever it is free.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v_r   <= 1'b0;
            s1_pg_r  <= {2*WIDTH{1'b0}};
            s1_h_r   <= {WIDTH{1'b0}};
            s1_a15_r <= 1'b0;
            s1_b15_r <= 1'b0;
            s1_c0_r  <= 1'b0;
            s1_tag_r <= {TAG_W{1'b0}};
        end else if (s1_free_s) begin
            s1_v_r <= in_valid;
            if (in_valid) begin
                s1_pg_r  <= lvl2_s;
                s1_h_r   <= half_s;
                s1_a15_r <= in_a[WIDTH-1];
                s1_b15_r <= b_eff_s[WIDTH-1];
                s1_c0_r  <= c0_s;
                s1_tag_r <= in_tag;
            end
        end
    end

    // Stage 2 register: takes stage 1 content when free, holds otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_v_r   <= 1'b0;
            s2_g_r   <= {WIDTH{1'b0}};
            s2_h_r   <= {WIDTH{1'b0}};
            s2_a15_r <= 1'b0;
            s2_b15_r <= 1'b0;
            s2_c0_r  <= 1'b0;
            s2_tag_r <= {TAG_W{1'b0}};
        end else if (s2_free_s) begin
            s2_v_r <= s1_v_r;
            if (s1_v_r) begin
                s2_g_r   <= lvl4_g_s;
                s2_h_r   <= s1_h_r;
                s2_a15_r <= s1_a15_r;
                s2_b15_r <= s1_b15_r;
                s2_c0_r  <= s1_c0_r;
                s2_tag_r <= s1_tag_r;
            end
        end
    end

    // Output register: result fields only change when a new result is loaded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_sum_r   <= {WIDTH{1'b0}};
            out_cout_r  <= 1'b0;
            out_ovf_r   <= 1'b0;
            out_zero_r  <= 1'b0;
            out_tag_r   <= {TAG_W{1'b0}};
        end else if (s3_free_s) begin
            out_valid_r <= s2_v_r;
            if (s2_v_r) begin
                out_sum_r  <= sum_s;
                out_cout_r <= cout_s;
                out_ovf_r  <= ovf_s;
                out_zero_r <= zero_s;
                out_tag_r  <= s2_tag_r;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_sum   = out_sum_r;
    assign out_cout  = out_cout_r;
    assign out_ovf   = out_ovf_r;
    assign out_zero  = out_zero_r;
    assign out_tag   = out_tag_r;

endmodule

// File: tb/tb_prefix_add_pipe.sv
// Testbench for prefix_add_pipe: directed table, multi-cycle sequences and
// random traffic checked by an arithmetic reference model and scoreboard.
module tb_prefix_add_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = 16'h0;
    logic [15:0] in_b = 16'h0;
    logic        in_sub = 1'b0;
    logic        in_cin = 1'b0;
    logic [3:0]  in_tag = 4'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic        out_zero;
    logic [3:0]  out_tag;

    always #5 clk = ~clk;

    prefix_add_pipe #(.WIDTH(16), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
        .out_zero(out_zero), .out_tag(out_tag)
    );

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic [3:0]  tag;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        cin;
        logic [3:0]  tag;
        logic [15:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } vec_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference: plain unsigned and signed integer arithmetic.
    function automatic exp_t ref_model(input logic [15:0] a, input logic [15:0] b,
                                       input logic sub, input logic cin, input logic [3:0] tag);
        exp_t        e;
        logic [15:0] bs;
        int          c;
        logic [31:0] total;
        int          sres;
        bs    = sub ? ~b : b;
        c     = sub ? 1 : (cin ? 1 : 0);
        total = 32'(a) + 32'(bs) + 32'(c);
        sres  = int'($signed(a)) + int'($signed(bs)) + c;
        e.sum  = total[15:0];
        e.cout = total[16];
        e.ovf  = (sres > 32767) || (sres < -32768);
        e.zero = (total[15:0] == 16'h0);
        e.tag  = tag;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Scoreboard: every visible result (stalled or not) must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
        end else begin
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_spurious: got out_valid=1 tag %0h want no result", out_tag);
                end else begin
                    chk("sb_result", {8'h0, out_sum, out_cout, out_ovf, out_zero, out_tag},
                        {8'h0, sbq[0].sum, sbq[0].cout, sbq[0].ovf, sbq[0].zero, sbq[0].tag});
                    if (out_ready) void'(sbq.pop_front());
                end
            end
            if (in_valid && in_ready)
                sbq.push_back(ref_model(in_a, in_b, in_sub, in_cin, in_tag));
        end
    end

    task automatic drive_rand(input logic [3:0] tag);
        in_a   = 16'($urandom);
        in_b   = 16'($urandom);
        in_sub = 1'($urandom);
        in_cin = 1'($urandom);
        in_tag = tag;
    endtask

    // One clock: report whether an input transfer happens at the coming edge.
    task automatic step(output bit acc);
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
    endtask

    // Issue one op into an empty pipe and check the 3-edge latency and result.
    task automatic issue_and_check(input vec_t v, input string name);
        @(posedge clk); #1;
        in_a = v.a; in_b = v.b; in_sub = v.sub; in_cin = v.cin; in_tag = v.tag;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({name, "_lat1"}, 32'(out_valid), 32'h0);
        @(posedge clk); #1;
        chk({name, "_lat2"}, 32'(out_valid), 32'h0);
        @(posedge clk); #1;
        chk(name, {8'h0, out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag},
            {8'h0, 1'b1, v.s, v.co, v.ov, v.z, v.tag});
    endtask

    vec_t tbl[7];

    initial begin
        bit acc;
        int k;
        int issued;
        int cycles;

        tbl[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 4'h5, 16'h5555, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 4'h1, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 4'h2, 16'h8000, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 4'h3, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 4'h4, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 4'h6, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 4'hF, 16'h0000, 1'b1, 1'b1, 1'b1};

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {8'h0, out_valid, in_ready, out_sum, out_cout, out_ovf, out_zero, out_tag},
            {8'h0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 4'h0});
        rst_n = 1'b1;

        // Directed table
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) issue_and_check(tbl[i], $sformatf("tbl%0d", i));
        @(posedge clk); #1;

        // Back-pressure: six tags, output stalled for six cycles
        out_ready = 1'b0;
        k = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc == 6) out_ready = 1'b1;
            if (k < 6) begin
                drive_rand(4'(k));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step(acc);
            if (acc) k++;
            if (cyc >= 2 && cyc <= 5)
                chk("bp_full", {in_ready, out_valid, out_tag}, {1'b0, 1'b1, 4'h0});
            if (cyc >= 6 && cyc <= 10)
                chk("bp_order", {out_valid, out_tag}, {1'b1, 4'(cyc - 5)});
            if (cyc == 11)
                chk("bp_empty", 32'(out_valid), 32'h0);
        end
        chk("bp_accepted", 32'(k), 32'd6);

        // Bubble collapse: op, idle, op, with output stalled
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (cyc == 0) begin
                drive_rand(4'h1);
                in_valid = 1'b1;
            end else if (cyc == 2) begin
                drive_rand(4'h2);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step(acc);
            chk("bubble_in_ready", 32'(in_ready), 32'h1);
            if (cyc >= 2)
                chk("bubble_hold", {out_valid, out_tag}, {1'b1, 4'h1});
        end
        out_ready = 1'b1;
        step(acc);
        chk("bubble_second", {out_valid, out_tag}, {1'b1, 4'h2});
        step(acc);
        chk("bubble_drained", 32'(out_valid), 32'h0);

        // Reset mid-flight with two ops inside
        drive_rand(4'h7);
        in_valid = 1'b1;
        step(acc);
        drive_rand(4'h8);
        step(acc);
        in_valid = 1'b0;
        rst_n = 1'b0;
        step(acc);
        chk("midreset_state", {8'h0, out_valid, in_ready, out_sum, out_cout, out_ovf, out_zero, out_tag},
            {8'h0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 4'h0});
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            step(acc);
            chk("midreset_no_stale", 32'(out_valid), 32'h0);
        end
        issue_and_check(tbl[0], "post_reset");
        @(posedge clk); #1;

        // Random traffic with random back-pressure
        issued = 0;
        cycles = 0;
        while (issued < 10000 && cycles < 40000) begin
            drive_rand(4'($urandom));
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            step(acc);
            if (acc) issued++;
            cycles++;
        end
        chk("random_issued", 32'(issued), 32'd10000);

        // Drain
        in_valid = 1'b0;
        out_ready = 1'b1;
        cycles = 0;
        while (sbq.size() != 0 && cycles < 20) begin
            step(acc);
            cycles++;
        end
        chk("drain_empty", 32'(sbq.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
